// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_e   : sequencer state encoding (RUN / EX_WAIT / MEM_WAIT)
//   REG_IDX_W : architectural register index width
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    // StRun = RUN, StExWait = EX_WAIT, StMemWait = MEM_WAIT
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StExWait  = 2'd1,
        StMemWait = 2'd2
    } state_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard detector.
// Flags when the instruction in EX is a register-writing load whose
// destination (non-x0) is a source actually read by the instruction in ID.
// Ports:
//   i_id_rs1, i_id_rs2         : ID source register indices
//   i_id_use_rs1, i_id_use_rs2 : ID instruction reads that source
//   i_ex_rd                    : EX destination register index
//   i_ex_mem_read              : EX instruction is a load
//   i_ex_reg_write             : EX instruction writes a register
//   o_load_use                 : hazard present
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_use_rs1,
    input  logic                 i_id_use_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_mem_read,
    input  logic                 i_ex_reg_write,
    output logic                 o_load_use
);

    logic w_ld_writes;
    logic w_hit_rs1;
    logic w_hit_rs2;

    // x0 never carries a dependency.
    assign w_ld_writes = i_ex_mem_read & i_ex_reg_write & (i_ex_rd != '0);
    assign w_hit_rs1   = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2   = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_load_use  = w_ld_writes & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush sequencer for the five-stage pipeline. Resolves, in
// priority order: memory wait, multi-cycle EX wait, control redirect, load-use.
// Owns the FSM that launches and tracks the multi-cycle EX unit.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/rs2  : ID source fields
//   ex_rd, ex_mem_read, ex_reg_write : EX destination / load info
//   ex_multi, ex_finish            : multi-cycle request / result-valid pulse
//   ex_redirect                    : taken branch / jalr in EX
//   mem_access, mem_finish         : MEM access in progress / completing
//   pc_stall, IF_flush, ID_stall, ID_flush, EX_stall,
//   MEM_stall, MEM_bubble, WB_bubble : pipeline register hold/clear controls
//   ex_start                       : launch pulse to the multi-cycle unit
//   ex_busy                        : state is EX_WAIT
//   stall_cnt, flush_cnt           : perf counters (PIPELINE_CTRL_PERF_EN only)
// Optional feature macro: PIPELINE_CTRL_PERF_EN
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write,
    input  logic                 ex_multi,
    input  logic                 ex_finish,
    input  logic                 ex_redirect,
    input  logic                 mem_access,
    input  logic                 mem_finish,
    output logic                 pc_stall,
    output logic                 IF_flush,
    output logic                 ID_stall,
    output logic                 ID_flush,
    output logic                 EX_stall,
    output logic                 MEM_stall,
    output logic                 MEM_bubble,
    output logic                 WB_bubble,
    output logic                 ex_start,
    output logic                 ex_busy
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_ex_done;
    logic   w_ex_done_nxt;
    logic   w_mem_hold;
    logic   w_load_use;

    assign w_mem_hold = mem_access & ~mem_finish;

    load_use_detect u_load_use_detect (
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (id_use_rs1),
        .i_id_use_rs2   (id_use_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_reg_write (ex_reg_write),
        .o_load_use     (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StRun;
            r_ex_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ex_done <= w_ex_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ex_done_nxt = r_ex_done;
        pc_stall      = 1'b0;
        IF_flush      = 1'b0;
        ID_stall      = 1'b0;
        ID_flush      = 1'b0;
        EX_stall      = 1'b0;
        MEM_stall     = 1'b0;
        MEM_bubble    = 1'b0;
        WB_bubble     = 1'b0;
        ex_start      = 1'b0;
        ex_busy       = 1'b0;

        if (rst_n) begin
            if (w_mem_hold) begin
                // Memory stall freezes everything up to EX/MEM and drains WB.
                pc_stall  = 1'b1;
                ID_stall  = 1'b1;
                EX_stall  = 1'b1;
                MEM_stall = 1'b1;
                WB_bubble = 1'b1;
            end

            case (r_state)
                StRun: begin
                    if (w_mem_hold) begin
                        w_state_nxt = StMemWait;
                    end else if (ex_multi) begin
                        // Launch cycle already holds the front end: it is the
                        // first of the N stall cycles of the operation.
                        ex_start    = 1'b1;
                        pc_stall    = 1'b1;
                        ID_stall    = 1'b1;
                        EX_stall    = 1'b1;
                        MEM_bubble  = 1'b1;
                        w_state_nxt = StExWait;
                    end else if (ex_redirect) begin
                        // Wrong-path IF and ID slots are squashed; PC takes target.
                        IF_flush = 1'b1;
                        ID_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_stall = 1'b1;
                        ID_stall = 1'b1;
                        ID_flush = 1'b1;
                    end
                end
                StExWait: begin
                    ex_busy = 1'b1;
                    if (w_mem_hold) begin
                        // Result may land while MEM is frozen; remember it.
                        if (ex_finish) begin
                            w_ex_done_nxt = 1'b1;
                        end
                    end else if (ex_finish || r_ex_done) begin
                        w_state_nxt   = StRun;
                        w_ex_done_nxt = 1'b0;
                    end else begin
                        pc_stall   = 1'b1;
                        ID_stall   = 1'b1;
                        EX_stall   = 1'b1;
                        MEM_bubble = 1'b1;
                    end
                end
                StMemWait: begin
                    if (mem_finish) begin
                        w_state_nxt = StRun;
                    end
                end
                default: begin
                    w_state_nxt   = StRun;
                    w_ex_done_nxt = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (IF_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model of the
// hazard rules. Perf counters are checked when PIPELINE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct packed {
        logic pc_stall;
        logic if_flush;
        logic id_stall;
        logic id_flush;
        logic ex_stall;
        logic mem_stall;
        logic mem_bubble;
        logic wb_bubble;
        logic ex_start;
        logic ex_busy;
    } outs_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                 id_use_rs1, id_use_rs2;
    logic                 ex_mem_read, ex_reg_write, ex_multi, ex_finish, ex_redirect;
    logic                 mem_access, mem_finish;
    logic                 pc_stall, IF_flush, ID_stall, ID_flush, EX_stall;
    logic                 MEM_stall, MEM_bubble, WB_bubble, ex_start, ex_busy;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0]          stall_cnt, flush_cnt;
`endif

    pipeline_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_multi     (ex_multi),
        .ex_finish    (ex_finish),
        .ex_redirect  (ex_redirect),
        .mem_access   (mem_access),
        .mem_finish   (mem_finish),
        .pc_stall     (pc_stall),
        .IF_flush     (IF_flush),
        .ID_stall     (ID_stall),
        .ID_flush     (ID_flush),
        .EX_stall     (EX_stall),
        .MEM_stall    (MEM_stall),
        .MEM_bubble   (MEM_bubble),
        .WB_bubble    (WB_bubble),
        .ex_start     (ex_start),
        .ex_busy      (ex_busy)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    outs_t dut_o;
    assign dut_o = {pc_stall, IF_flush, ID_stall, ID_flush, EX_stall,
                    MEM_stall, MEM_bubble, WB_bubble, ex_start, ex_busy};

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: is a multi-cycle op outstanding, is memory known stalled,
    // has a result arrived early, and how many stall/flush cycles so far.
    bit          m_op_pending;
    bit          m_mem_blocked;
    bit          m_result_early;
    int unsigned m_stalls;
    int unsigned m_flushes;
    outs_t       exp_o;
    logic        prev_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic outs_t predict();
        outs_t o;
        bit    mem_blocking;
        bit    hazard;
        o = '0;
        mem_blocking = mem_access && !mem_finish;
        hazard = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (!rst_n) return o;
        o.ex_busy = m_op_pending;
        if (mem_blocking) begin
            o.pc_stall = 1; o.id_stall = 1; o.ex_stall = 1; o.mem_stall = 1;
            o.wb_bubble = 1;
        end else if (m_op_pending) begin
            if (!(ex_finish || m_result_early)) begin
                o.pc_stall = 1; o.id_stall = 1; o.ex_stall = 1; o.mem_bubble = 1;
            end
        end else if (!m_mem_blocked) begin
            if (ex_multi) begin
                o.ex_start = 1;
                o.pc_stall = 1; o.id_stall = 1; o.ex_stall = 1; o.mem_bubble = 1;
            end else if (ex_redirect) begin
                o.if_flush = 1; o.id_flush = 1;
            end else if (hazard) begin
                o.pc_stall = 1; o.id_stall = 1; o.id_flush = 1;
            end
        end
        return o;
    endfunction

    task automatic advance_model(input outs_t o);
        bit mem_blocking;
        mem_blocking = mem_access && !mem_finish;
        if (!rst_n) begin
            m_op_pending = 0; m_mem_blocked = 0; m_result_early = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (o.pc_stall) m_stalls++;
            if (o.if_flush) m_flushes++;
            if (m_op_pending) begin
                if (mem_blocking) begin
                    if (ex_finish) m_result_early = 1;
                end else if (ex_finish || m_result_early) begin
                    m_op_pending = 0; m_result_early = 0;
                end
            end else if (m_mem_blocked) begin
                if (mem_finish) m_mem_blocked = 0;
            end else if (mem_blocking) begin
                m_mem_blocked = 1;
            end else if (ex_multi) begin
                m_op_pending = 1;
            end
        end
    endtask

    // Settle and compare the whole output vector against the model.
    task automatic sample(input string tag);
        @(negedge clk);
        exp_o = predict();
        chk(tag, 32'(dut_o), 32'(exp_o));
`ifdef PIPELINE_CTRL_PERF_EN
        chk({tag, "_scnt"}, stall_cnt, m_stalls);
        chk({tag, "_fcnt"}, flush_cnt, m_flushes);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        advance_model(exp_o);
        #1;
    endtask

    task automatic quiet();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_multi = 0; ex_finish = 0;
        ex_redirect = 0; mem_access = 0; mem_finish = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd; id_rs1 = 5; id_use_rs1 = 1;
    endtask

    initial begin
        m_op_pending = 0; m_mem_blocked = 0; m_result_early = 0;
        m_stalls = 0; m_flushes = 0; prev_start = 0;
        quiet();
        // Reset with busy inputs: everything must read 0.
        rst_n = 0; ex_multi = 1; ex_redirect = 1; mem_access = 1;
        @(posedge clk); #1;
        sample("reset_outs"); chk("reset_zero", 32'(dut_o), 0); tick();
        quiet(); rst_n = 1;
        sample("idle"); tick();

        // Load-use on rs1 = x5.
        set_load_use(5);
        sample("lu"); chk("lu_pc", pc_stall, 1); chk("lu_idst", ID_stall, 1);
        chk("lu_idfl", ID_flush, 1); tick();
        quiet(); sample("lu_after"); chk("lu_once", pc_stall, 0); tick();
        set_load_use(0); id_rs1 = 0;
        sample("lu_x0"); chk("lu_x0_pc", pc_stall, 0); tick();

        // Redirect outranks load-use.
        set_load_use(5); ex_redirect = 1;
        sample("redir"); chk("redir_if", IF_flush, 1); chk("redir_id", ID_flush, 1);
        chk("redir_pc", pc_stall, 0); tick();
        quiet();

        // Multi-cycle op, finish 4 cycles after start.
        ex_multi = 1;
        sample("mc_start"); chk("mc_start_p", ex_start, 1); tick();
        for (int i = 1; i <= 3; i++) begin
            sample("mc_wait"); chk("mc_busy", ex_busy, 1); chk("mc_nostart", ex_start, 0);
            tick();
        end
        ex_finish = 1;
        sample("mc_fin"); chk("mc_fin_busy", ex_busy, 1); chk("mc_fin_pc", pc_stall, 0);
        tick();
        quiet(); sample("mc_run"); chk("mc_run_busy", ex_busy, 0); tick();

        // Memory wait inside EX_WAIT, result arrives during the stall.
        ex_multi = 1; sample("mw_start"); tick();
        ex_multi = 0; sample("mw_busy"); tick();
        mem_access = 1;
        for (int i = 0; i < 3; i++) begin
            ex_finish = (i == 1);
            sample("mw_hold"); chk("mw_wb", WB_bubble, 1); chk("mw_memst", MEM_stall, 1);
            tick();
        end
        ex_finish = 0; mem_finish = 1;
        sample("mw_rel"); chk("mw_rel_pc", pc_stall, 0); chk("mw_rel_st", ex_start, 0);
        tick();
        quiet(); sample("mw_run"); chk("mw_run_busy", ex_busy, 0); tick();

        // Reset mid-EX_WAIT abandons the op.
        ex_multi = 1; sample("rs_start"); tick();
        ex_multi = 0; sample("rs_busy"); tick();
        rst_n = 0; sample("rs_in"); chk("rs_in_zero", 32'(dut_o), 0); tick();
        rst_n = 1; sample("rs_out"); chk("rs_out_busy", ex_busy, 0);
        chk("rs_out_st", ex_start, 0); tick();

`ifdef PIPELINE_CTRL_PERF_EN
        chk("perf_zero", stall_cnt, 0);
        set_load_use(5);
        for (int i = 0; i < 7; i++) begin
            sample("perf_lu"); tick();
        end
        quiet(); sample("perf_idle"); chk("perf_seven", stall_cnt, 7); tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            ex_mem_read  = 1'($urandom);
            ex_reg_write = 1'($urandom);
            ex_multi     = ($urandom_range(0, 5) == 0);
            ex_finish    = ($urandom_range(0, 3) == 0);
            ex_redirect  = ($urandom_range(0, 3) == 0);
            mem_access   = ($urandom_range(0, 2) == 0);
            mem_finish   = 1'($urandom);
            sample("rand");
            chk("rand_gap", prev_start & ex_start, 0);
            prev_start = ex_start;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
